// File: rtl/scope_pkg.sv
// Shared types for the XY vector-scope frame player: point word layout and FSM states.
package scope_pkg;

  localparam int unsigned CoordWidth = 8;

  typedef struct packed {
    logic                  blank;
    logic [CoordWidth-1:0] x;
    logic [CoordWidth-1:0] y;
  } point_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHOW  = 2'd2
  } state_t;

endpackage

// File: rtl/scope_point_ram.sv
// Simple dual-port point memory: registered read, read-first on address collision, no reset.
module scope_point_ram
  import scope_pkg::*;
#(
  parameter int unsigned Depth = 64
) (
  input  logic                     clk_i,
  input  logic                     wr_en,
  input  logic [$clog2(Depth)-1:0] wr_addr,
  input  point_t                   wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(Depth)-1:0] rd_addr,
  output point_t                   rd_data
);

  point_t mem [Depth];

  // Both updates are non-blocking, so a same-address read sees the old word.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/xy_frame_player.sv
// Plays a list of XY points from point memory to the beam DACs, each held for dwell+1 cycles,
// once or looping, with a frame counter and end-of-frame pulse.
//
// state | meaning
// IDLE  | waiting for start; beam blanked, last X/Y held
// FETCH | one cycle reading point 0
// SHOW  | driving the current point; next point read in its last dwell cycle
module xy_frame_player
  import scope_pkg::*;
#(
  parameter int unsigned Depth      = 64,
  parameter int unsigned DwellWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [$clog2(Depth)-1:0] wr_addr_i,
  input  logic [16:0]              wr_data_i,
  input  logic [$clog2(Depth):0]   len_i,
  input  logic [DwellWidth-1:0]    dwell_i,
  input  logic                     loop_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  output logic [CoordWidth-1:0]    o_x,
  output logic [CoordWidth-1:0]    o_y,
  output logic                     o_blank,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic [15:0]              frame_cnt_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] LenMax = (AW+1)'(Depth);

  state_t                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d, last_q, last_d, rd_addr;
  logic [DwellWidth-1:0] dwell_q, dwell_d, dcnt_q, dcnt_d;
  logic                  loop_q, loop_d, stop_q, stop_d, shown_q, shown_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  rd_en, frame_end, len_ok, cont;
  logic [AW:0]           len_clamped, len_minus1;
  logic [AW-1:0]         len_last;
  point_t                wr_point, rd_data;

  assign wr_point    = wr_data_i;
  assign len_clamped = (len_i > LenMax) ? LenMax : len_i;
  assign len_minus1  = len_clamped - 1'b1;
  assign len_last    = len_minus1[AW-1:0];
  assign len_ok      = (len_i != '0);
  // A stop arriving in the frame-end cycle must still end playback there.
  assign cont        = loop_q && !stop_q && !stop_i && len_ok;

  scope_point_ram #(.Depth(Depth)) u_ram (
    .clk_i   (clk_i),
    .wr_en   (wr_en_i),
    .wr_addr (wr_addr_i),
    .wr_data (wr_point),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      last_q      <= '0;
      dwell_q     <= '0;
      dcnt_q      <= '0;
      loop_q      <= 1'b0;
      stop_q      <= 1'b0;
      shown_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      dwell_q     <= dwell_d;
      dcnt_q      <= dcnt_d;
      loop_q      <= loop_d;
      stop_q      <= stop_d;
      shown_q     <= shown_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_d      = last_q;
    dwell_d     = dwell_q;
    dcnt_d      = dcnt_q;
    loop_d      = loop_q;
    stop_d      = stop_q;
    shown_d     = shown_q;
    frame_cnt_d = frame_cnt_q;
    rd_en       = 1'b0;
    rd_addr     = '0;
    frame_end   = 1'b0;
    if (state_q != IDLE && stop_i) stop_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (start_i && !stop_i && len_ok) begin
          state_d = FETCH;
          last_d  = len_last;
          dwell_d = dwell_i;
          loop_d  = loop_i;
        end
      end
      FETCH: begin
        rd_en   = 1'b1;
        addr_d  = '0;
        dcnt_d  = dwell_q;
        shown_d = 1'b1;
        state_d = SHOW;
      end
      SHOW: begin
        if (dcnt_q != '0) begin
          dcnt_d = dcnt_q - 1'b1;
        end else if (addr_q != last_q) begin
          rd_en   = 1'b1;
          rd_addr = addr_q + 1'b1;
          addr_d  = addr_q + 1'b1;
          dcnt_d  = dwell_q;
        end else begin
          frame_end   = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (cont) begin
            rd_en   = 1'b1;
            addr_d  = '0;
            last_d  = len_last;
            dwell_d = dwell_i;
            loop_d  = loop_i;
            dcnt_d  = dwell_i;
          end else begin
            // No read here, so the RAM output keeps the last point for X/Y hold.
            state_d = IDLE;
            stop_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_x          = shown_q ? rd_data.x : '0;
  assign o_y          = shown_q ? rd_data.y : '0;
  assign o_blank      = (state_q == SHOW) ? rd_data.blank : 1'b1;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = frame_end;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_xy_frame_player.sv
// Scoreboard bench for xy_frame_player: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_xy_frame_player;

  localparam int unsigned Depth = 4;
  localparam int unsigned AW    = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          wr_en_i = 1'b0;
  logic [AW-1:0] wr_addr_i = '0;
  logic [16:0]   wr_data_i = '0;
  logic [AW:0]   len_i = '0;
  logic [7:0]    dwell_i = '0;
  logic          loop_i = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic [7:0]    o_x, o_y;
  logic          o_blank, busy_o, frame_done_o;
  logic [15:0]   frame_cnt_o;

  xy_frame_player #(.Depth(Depth), .DwellWidth(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .len_i(len_i), .dwell_i(dwell_i), .loop_i(loop_i),
    .start_i(start_i), .stop_i(stop_i), .o_x(o_x), .o_y(o_y), .o_blank(o_blank),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        busy;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        blank;
    logic        done;
    logic [15:0] cnt;
  } snap_t;

  snap_t q[$];
  int    n_vec = 0;
  int    n_err = 0;
  string test_name = "reset";

  always @(negedge clk_i) begin
    if (q.size() > 0) begin
      snap_t e, g;
      e = q.pop_front();
      g = '{busy_o, o_x, o_y, o_blank, frame_done_o, frame_cnt_o};
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL %s vec %0d: got busy=%0d x=%0d y=%0d blank=%0d done=%0d cnt=%0d, want busy=%0d x=%0d y=%0d blank=%0d done=%0d cnt=%0d",
                 test_name, n_vec, g.busy, g.x, g.y, g.blank, g.done, g.cnt,
                 e.busy, e.x, e.y, e.blank, e.done, e.cnt);
      end
    end
  end

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ex(input logic b, input int x, input int y, input logic bl,
                    input logic d, input int c, input int reps);
    for (int i = 0; i < reps; i++) q.push_back('{b, 8'(x), 8'(y), bl, d, 16'(c)});
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] x, input logic [7:0] y, input logic bl);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = {bl, x, y};
    cycle();
    wr_en_i = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() > 0 && k < 50) begin
      cycle();
      k++;
    end
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL %s drain: %0d expected vectors never consumed", test_name, q.size());
      q.delete();
    end
  endtask

  // Caller sets the cycle-0 inputs; per-cycle pulses are applied at cycle index i.
  task automatic run(input int n, input int stop_at, input int start_at, input int wr_at,
                     input logic [AW-1:0] wa, input logic [16:0] wd);
    for (int i = 1; i <= n; i++) begin
      cycle();
      start_i = (i == start_at);
      stop_i = (i == stop_at);
      wr_en_i = (i == wr_at);
      wr_addr_i = wa;
      wr_data_i = wd;
    end
    start_i = 1'b0; stop_i = 1'b0; wr_en_i = 1'b0;
    drain();
  endtask

  initial begin
    ex(0, 0, 0, 1, 0, 0, 2);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    drain();

    wr(0, 8'd10, 8'd20, 1'b0);
    wr(1, 8'd30, 8'd40, 1'b0);
    wr(2, 8'd50, 8'd60, 1'b0);
    wr(3, 8'd70, 8'd80, 1'b1);

    test_name = "single_frame";
    len_i = 4; dwell_i = 2; loop_i = 0; start_i = 1;
    ex(0, 0, 0, 1, 0, 0, 1);
    ex(1, 0, 0, 1, 0, 0, 1);
    ex(1, 10, 20, 0, 0, 0, 3);
    ex(1, 30, 40, 0, 0, 0, 3);
    ex(1, 50, 60, 0, 0, 0, 3);
    ex(1, 70, 80, 1, 0, 0, 2);
    ex(1, 70, 80, 1, 1, 0, 1);
    ex(0, 70, 80, 1, 0, 1, 2);
    run(15, 0, 0, 0, '0, '0);

    test_name = "loop_stop_mid";
    len_i = 3; dwell_i = 0; loop_i = 1; start_i = 1;
    ex(0, 70, 80, 1, 0, 1, 1);
    ex(1, 70, 80, 1, 0, 1, 1);
    for (int f = 1; f <= 3; f++) begin
      ex(1, 10, 20, 0, 0, f, 1);
      ex(1, 30, 40, 0, 0, f, 1);
      ex(1, 50, 60, 0, 1, f, 1);
    end
    ex(0, 50, 60, 1, 0, 4, 2);
    run(12, 9, 0, 0, '0, '0);

    test_name = "stop_at_frame_end";
    start_i = 1;
    ex(0, 50, 60, 1, 0, 4, 1);
    ex(1, 50, 60, 1, 0, 4, 1);
    ex(1, 10, 20, 0, 0, 4, 1);
    ex(1, 30, 40, 0, 0, 4, 1);
    ex(1, 50, 60, 0, 1, 4, 1);
    ex(0, 50, 60, 1, 0, 5, 2);
    run(6, 4, 0, 0, '0, '0);

    test_name = "start_len0";
    len_i = 0; start_i = 1;
    ex(0, 50, 60, 1, 0, 5, 3);
    run(2, 0, 0, 0, '0, '0);

    test_name = "start_with_stop_idle";
    len_i = 3; start_i = 1; stop_i = 1;
    ex(0, 50, 60, 1, 0, 5, 3);
    run(2, 0, 0, 0, '0, '0);

    test_name = "stop_only_idle";
    stop_i = 1;
    ex(0, 50, 60, 1, 0, 5, 2);
    run(1, 0, 0, 0, '0, '0);

    test_name = "write_during_fetch";
    len_i = 3; dwell_i = 1; loop_i = 1; start_i = 1;
    ex(0, 50, 60, 1, 0, 5, 1);
    ex(1, 50, 60, 1, 0, 5, 1);
    ex(1, 10, 20, 0, 0, 5, 2);
    ex(1, 30, 40, 0, 0, 5, 2);
    ex(1, 50, 60, 0, 0, 5, 1);
    ex(1, 50, 60, 0, 1, 5, 1);
    ex(1, 10, 20, 0, 0, 6, 2);
    ex(1, 99, 88, 0, 0, 6, 2);
    ex(1, 50, 60, 0, 0, 6, 1);
    ex(1, 50, 60, 0, 1, 6, 1);
    ex(0, 50, 60, 1, 0, 7, 2);
    run(15, 11, 0, 3, 2'd1, {1'b0, 8'd99, 8'd88});

    test_name = "len_clamp_busy_start";
    len_i = 7; dwell_i = 0; loop_i = 0; start_i = 1;
    ex(0, 50, 60, 1, 0, 7, 1);
    ex(1, 50, 60, 1, 0, 7, 1);
    ex(1, 10, 20, 0, 0, 7, 1);
    ex(1, 99, 88, 0, 0, 7, 1);
    ex(1, 50, 60, 0, 0, 7, 1);
    ex(1, 70, 80, 1, 1, 7, 1);
    ex(0, 70, 80, 1, 0, 8, 2);
    run(7, 0, 3, 0, '0, '0);

    test_name = "reset_mid_show";
    len_i = 4; dwell_i = 2; loop_i = 1; start_i = 1;
    ex(0, 70, 80, 1, 0, 8, 1);
    ex(1, 70, 80, 1, 0, 8, 1);
    ex(1, 10, 20, 0, 0, 8, 2);
    ex(0, 0, 0, 1, 0, 0, 3);
    cycle();
    start_i = 0;
    repeat (3) cycle();
    rst_ni = 1'b0;
    cycle();
    cycle();
    rst_ni = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
